// File: rtl/pattern_history_table_if.sv
// Lookup and update bus between the fetch/resolve pipeline and the gshare pattern history table.
interface pattern_history_table_if #(
    parameter int REGSIZE = 2,
    parameter int IDX_W   = 4
);
    logic               pred_valid;
    logic [31:0]        pred_pc;
    logic [REGSIZE-1:0] bhr;
    logic               pred_out_valid;
    logic               pred_taken;
    logic [IDX_W-1:0]   pred_idx;
    logic               upd_valid;
    logic [IDX_W-1:0]   upd_idx;
    logic               upd_taken;
    logic               bhr_en;
    logic               bhr_in;

    modport master (
        output pred_valid, pred_pc, bhr, upd_valid, upd_idx, upd_taken,
        input  pred_out_valid, pred_taken, pred_idx, bhr_en, bhr_in
    );

    modport slave (
        input  pred_valid, pred_pc, bhr, upd_valid, upd_idx, upd_taken,
        output pred_out_valid, pred_taken, pred_idx, bhr_en, bhr_in
    );
endinterface

// File: rtl/pattern_history_table.sv
// Table of 2-bit saturating counters giving registered taken/not-taken predictions.
// Define PHT_GSHARE_EN to hash the PC with global history (gshare); otherwise bimodal PC indexing.
module pattern_history_table #(
    parameter int REGSIZE = 2,
    parameter int IDX_W   = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    pattern_history_table_if.slave bus
);
    localparam int DEPTH = 1 << IDX_W;

    logic [1:0]       ctr_r [DEPTH];
    logic             pred_out_valid_r;
    logic             pred_taken_r;
    logic [IDX_W-1:0] pred_idx_r;

    logic [IDX_W-1:0] pc_idx_s;
    logic [IDX_W-1:0] lookup_idx_s;
    logic [1:0]       upd_next_s;
    logic             pred_taken_s;
    logic             unused_s;

    function automatic logic [1:0] sat_step(input logic [1:0] ctr, input logic taken);
        logic [1:0] nxt;
        case ({taken, ctr})
            3'b100:  nxt = 2'b01;
            3'b101:  nxt = 2'b10;
            3'b110:  nxt = 2'b11;
            3'b111:  nxt = 2'b11;
            3'b000:  nxt = 2'b00;
            3'b001:  nxt = 2'b00;
            3'b010:  nxt = 2'b01;
            3'b011:  nxt = 2'b10;
            default: nxt = 2'b01;
        endcase
        return nxt;
    endfunction

    // Index hashing, counter next-state and same-cycle forwarding of the update.
    always_comb begin
        pc_idx_s = bus.pred_pc[IDX_W+1:2];
`ifdef PHT_GSHARE_EN
        lookup_idx_s = pc_idx_s ^ IDX_W'(bus.bhr);
`else
        lookup_idx_s = pc_idx_s;
`endif
        upd_next_s = sat_step(ctr_r[bus.upd_idx], bus.upd_taken);
        if (bus.upd_valid && (bus.upd_idx == lookup_idx_s)) begin
            pred_taken_s = upd_next_s[1];
        end else begin
            pred_taken_s = ctr_r[lookup_idx_s][1];
        end
    end

    // Counter storage: reset to weakly not-taken, trained on resolution.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                ctr_r[i] <= 2'b01;
            end
        end else if (bus.upd_valid) begin
            ctr_r[bus.upd_idx] <= upd_next_s;
        end
    end

    // Prediction output registers; taken and index hold while no lookup arrives.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pred_out_valid_r <= 1'b0;
            pred_taken_r     <= 1'b0;
            pred_idx_r       <= {IDX_W{1'b0}};
        end else begin
            pred_out_valid_r <= bus.pred_valid;
            if (bus.pred_valid) begin
                pred_taken_r <= pred_taken_s;
                pred_idx_r   <= lookup_idx_s;
            end
        end
    end

    assign bus.pred_out_valid = pred_out_valid_r;
    assign bus.pred_taken     = pred_taken_r;
    assign bus.pred_idx       = pred_idx_r;

    // History shift controls bypass the table so the register shifts on the training edge.
    assign bus.bhr_en = bus.upd_valid;
    assign bus.bhr_in = bus.upd_taken;

    assign unused_s = ^{bus.pred_pc[31:IDX_W+2], bus.pred_pc[1:0], bus.bhr};
endmodule

// File: tb/tb_pattern_history_table.sv
// Scoreboard bench for pattern_history_table: a counter model predicts each output cycle.
module tb_pattern_history_table;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    pattern_history_table_if #(.REGSIZE(2), .IDX_W(4)) bus ();

    pattern_history_table #(.REGSIZE(2), .IDX_W(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    typedef struct packed {
        logic       v;
        logic       taken;
        logic [3:0] idx;
    } exp_t;

    exp_t       sb[$];
    exp_t       e;
    logic [1:0] model [16];
    logic       last_taken;
    logic [3:0] last_idx;

    function automatic logic [3:0] idx_of(input logic [31:0] pc, input logic [1:0] bh);
`ifdef PHT_GSHARE_EN
        return pc[5:2] ^ {2'b00, bh};
`else
        return pc[5:2];
`endif
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 16; i++) model[i] = 2'b01;
        last_taken = 1'b0;
        last_idx   = 4'd0;
        sb.delete();
    endtask

    // Drive one cycle at the falling edge, push the modelled output, sample after the rising edge.
    task automatic step(input logic pv, input logic [31:0] pc, input logic [1:0] bh,
                        input logic uv, input logic [3:0] ui, input logic ut);
        logic [3:0] li;
        logic [1:0] nxt;
        exp_t       x;
        @(negedge clk);
        bus.pred_valid = pv;
        bus.pred_pc    = pc;
        bus.bhr        = bh;
        bus.upd_valid  = uv;
        bus.upd_idx    = ui;
        bus.upd_taken  = ut;
        li  = idx_of(pc, bh);
        if (ut) nxt = (model[ui] == 2'b11) ? 2'b11 : model[ui] + 2'b01;
        else    nxt = (model[ui] == 2'b00) ? 2'b00 : model[ui] - 2'b01;
        if (pv) begin
            last_idx   = li;
            last_taken = (uv && ui == li) ? nxt[1] : model[li][1];
        end
        x.v     = pv;
        x.taken = last_taken;
        x.idx   = last_idx;
        sb.push_back(x);
        if (uv) model[ui] = nxt;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        step(1'b0, 32'h0, 2'b00, 1'b0, 4'd0, 1'b0);
        void'(sb.pop_front());
    endtask

    task automatic test_reset();
        logic [31:0] pcs [3];
        pcs[0] = 32'h0000_0000; pcs[1] = 32'h0000_0004; pcs[2] = 32'h0000_003C;
        bus.pred_valid = 1'b0; bus.pred_pc = 32'h0; bus.bhr = 2'b00;
        bus.upd_valid = 1'b0; bus.upd_idx = 4'd0; bus.upd_taken = 1'b0;
        rst = 1'b1;
        #12;
        checks++;
        if ({bus.pred_out_valid, bus.pred_taken, bus.pred_idx} !== 6'b0) begin
            errors++;
            $display("FAIL reset_outputs: got v=%b t=%b idx=%h, want 0 0 0",
                     bus.pred_out_valid, bus.pred_taken, bus.pred_idx);
        end
        rst = 1'b0;
        model_reset();
        for (int i = 0; i < 3; i++) begin
            step(1'b1, pcs[i], 2'b00, 1'b0, 4'd0, 1'b0);
            e = sb.pop_front();
            checks++;
            if (bus.pred_taken !== 1'b0 || bus.pred_out_valid !== 1'b1 || bus.pred_idx !== e.idx) begin
                errors++;
                $display("FAIL reset_lookup%0d: got v=%b t=%b idx=%h, want v=1 t=0 idx=%h",
                         i, bus.pred_out_valid, bus.pred_taken, bus.pred_idx, e.idx);
            end
        end
        // A taken update from 01 lands on 10, so a forwarded lookup must see taken everywhere.
        for (int i = 0; i < 16; i++) begin
            step(1'b1, 32'(i * 4), 2'b00, 1'b1, 4'(i), 1'b1);
            e = sb.pop_front();
            checks++;
            if ({bus.pred_out_valid, bus.pred_taken, bus.pred_idx} !== {e.v, e.taken, e.idx} || bus.pred_taken !== 1'b1) begin
                errors++;
                $display("FAIL reset_counter%0d: got v=%b t=%b idx=%h, want v=%b t=%b idx=%h",
                         i, bus.pred_out_valid, bus.pred_taken, bus.pred_idx, e.v, e.taken, e.idx);
            end
        end
    endtask

    task automatic test_training();
        logic       want [2];
        logic       dirs [2];
        want[0] = 1'b1; want[1] = 1'b0;
        dirs[0] = 1'b1; dirs[1] = 1'b0;
        for (int p = 0; p < 2; p++) begin
            step(1'b0, 32'h0, 2'b00, 1'b1, 4'd3, dirs[p]);
            void'(sb.pop_front());
            step(1'b0, 32'h0, 2'b00, 1'b1, 4'd3, dirs[p]);
            void'(sb.pop_front());
            step(1'b1, 32'h0000_000C, 2'b00, 1'b0, 4'd0, 1'b0);
            e = sb.pop_front();
            checks++;
            if ({bus.pred_out_valid, bus.pred_taken, bus.pred_idx} !== {e.v, e.taken, e.idx} || bus.pred_taken !== want[p]) begin
                errors++;
                $display("FAIL training%0d: got v=%b t=%b idx=%h, want v=%b t=%b idx=%h",
                         p, bus.pred_out_valid, bus.pred_taken, bus.pred_idx, e.v, e.taken, e.idx);
            end
        end
    endtask

    task automatic test_saturation();
        logic dirs [2];
        logic want [2];
        dirs[0] = 1'b1; dirs[1] = 1'b0;
        want[0] = 1'b1; want[1] = 1'b0;
        for (int p = 0; p < 2; p++) begin
            for (int k = 0; k < 5; k++) begin
                step(1'b0, 32'h0, 2'b00, 1'b1, 4'd5, dirs[p]);
                void'(sb.pop_front());
            end
            step(1'b0, 32'h0, 2'b00, 1'b1, 4'd5, ~dirs[p]);
            void'(sb.pop_front());
            step(1'b1, 32'h0000_0014, 2'b00, 1'b0, 4'd0, 1'b0);
            e = sb.pop_front();
            checks++;
            if ({bus.pred_out_valid, bus.pred_taken, bus.pred_idx} !== {e.v, e.taken, e.idx} || bus.pred_taken !== want[p]) begin
                errors++;
                $display("FAIL saturation%0d: got v=%b t=%b idx=%h, want v=%b t=%b idx=%h",
                         p, bus.pred_out_valid, bus.pred_taken, bus.pred_idx, e.v, e.taken, e.idx);
            end
        end
    endtask

    task automatic test_forwarding();
        // idx 7 sits at 10 after the reset sweep; one not-taken brings it to 01.
        step(1'b0, 32'h0, 2'b00, 1'b1, 4'd7, 1'b0);
        void'(sb.pop_front());
        step(1'b1, 32'h0000_001C, 2'b00, 1'b1, 4'd7, 1'b1);
        e = sb.pop_front();
        checks++;
        if ({bus.pred_out_valid, bus.pred_taken, bus.pred_idx} !== {e.v, e.taken, e.idx} || bus.pred_taken !== 1'b1) begin
            errors++;
            $display("FAIL forwarding: got v=%b t=%b idx=%h, want v=%b t=%b idx=%h",
                     bus.pred_out_valid, bus.pred_taken, bus.pred_idx, e.v, e.taken, e.idx);
        end
        checks++;
        if ({bus.bhr_en, bus.bhr_in} !== 2'b11) begin
            errors++;
            $display("FAIL bhr_ctrl: got en=%b in=%b, want en=1 in=1", bus.bhr_en, bus.bhr_in);
        end
        step(1'b0, 32'h0, 2'b00, 1'b1, 4'd2, 1'b0);
        e = sb.pop_front();
        checks++;
        if ({bus.bhr_en, bus.bhr_in} !== 2'b10 || {bus.pred_out_valid, bus.pred_taken, bus.pred_idx} !== {e.v, e.taken, e.idx}) begin
            errors++;
            $display("FAIL bhr_hold: got en=%b in=%b v=%b t=%b idx=%h, want en=1 in=0 v=%b t=%b idx=%h",
                     bus.bhr_en, bus.bhr_in, bus.pred_out_valid, bus.pred_taken, bus.pred_idx, e.v, e.taken, e.idx);
        end
    endtask

    task automatic test_indexing();
        logic [3:0] want;
`ifdef PHT_GSHARE_EN
        want = 4'b0111;
`else
        want = 4'b0100;
`endif
        step(1'b1, 32'h0000_0010, 2'b11, 1'b0, 4'd0, 1'b0);
        e = sb.pop_front();
        checks++;
        if (bus.pred_idx !== want || {bus.pred_out_valid, bus.pred_taken, bus.pred_idx} !== {e.v, e.taken, e.idx}) begin
            errors++;
            $display("FAIL indexing: got v=%b t=%b idx=%b, want v=%b t=%b idx=%b",
                     bus.pred_out_valid, bus.pred_taken, bus.pred_idx, e.v, e.taken, want);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] pc;
        logic [1:0]  bh;
        for (int i = 0; i < 24; i++) begin
            pc = $urandom;
            bh = 2'($urandom_range(0, 3));
            step(1'($urandom_range(0, 1)), pc, bh, 1'($urandom_range(0, 1)),
                 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
            e = sb.pop_front();
            checks++;
            if ({bus.pred_out_valid, bus.pred_taken, bus.pred_idx} !== {e.v, e.taken, e.idx}) begin
                errors++;
                $display("FAIL back_to_back%0d: got v=%b t=%b idx=%h, want v=%b t=%b idx=%h",
                         i, bus.pred_out_valid, bus.pred_taken, bus.pred_idx, e.v, e.taken, e.idx);
            end
        end
    endtask

    task automatic test_async_reset();
        step(1'b0, 32'h0, 2'b00, 1'b1, 4'd3, 1'b1);
        void'(sb.pop_front());
        step(1'b0, 32'h0, 2'b00, 1'b1, 4'd3, 1'b1);
        void'(sb.pop_front());
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 32'h0000_000C, 2'b00, 1'b0, 4'd0, 1'b0);
            void'(sb.pop_front());
        end
        checks++;
        if (bus.pred_taken !== 1'b1 || bus.pred_idx !== 4'd3) begin
            errors++;
            $display("FAIL pre_reset_trained: got t=%b idx=%h, want t=1 idx=3", bus.pred_taken, bus.pred_idx);
        end
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if ({bus.pred_out_valid, bus.pred_taken, bus.pred_idx} !== 6'b0) begin
            errors++;
            $display("FAIL async_reset: got v=%b t=%b idx=%h, want 0 0 0",
                     bus.pred_out_valid, bus.pred_taken, bus.pred_idx);
        end
        rst = 1'b0;
        model_reset();
        step(1'b1, 32'h0000_000C, 2'b00, 1'b0, 4'd0, 1'b0);
        e = sb.pop_front();
        checks++;
        if ({bus.pred_out_valid, bus.pred_taken, bus.pred_idx} !== {e.v, e.taken, e.idx} || bus.pred_taken !== 1'b0) begin
            errors++;
            $display("FAIL post_reset_idx3: got v=%b t=%b idx=%h, want v=%b t=%b idx=%h",
                     bus.pred_out_valid, bus.pred_taken, bus.pred_idx, e.v, e.taken, e.idx);
        end
    endtask

    initial begin
        test_reset();
        test_training();
        test_saturation();
        test_forwarding();
        test_indexing();
        test_back_to_back();
        test_async_reset();
        idle();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/pattern_history_table.md
# pattern_history_table

Branch direction predictor table that sits directly downstream of the branch history register in the 4-stage pipeline. It holds 2^IDX_W two-bit saturating counters and returns a registered taken/not-taken prediction for each fetch lookup. It indexes the table with the fetch PC hashed with the current global history (gshare). Branch resolution trains the table and drives the history register's shift-enable and shift-in inputs.

## Interface
- REGSIZE, 2, global history width; must equal the history register width and satisfy REGSIZE <= IDX_W
- IDX_W, 4, table index width; table depth = 2^IDX_W counters
- clk  input  1  clock, all state updates on rising edge
- rst  input  1  asynchronous, active-high reset
- pred_valid  input  1  fetch lookup request this cycle
- pred_pc  input  32  fetch PC of the lookup
- bhr  input  REGSIZE  current global history from the history register
- pred_out_valid  output  1  registered; high for one cycle after an accepted lookup
- pred_taken  output  1  registered prediction, 1 = taken
- pred_idx  output  IDX_W  registered table index used; carried down the pipeline and returned as upd_idx
- upd_valid  input  1  resolved branch update this cycle
- upd_idx  input  IDX_W  index captured at prediction time
- upd_taken  input  1  resolved direction
- bhr_en  output  1  history shift enable; combinational copy of upd_valid
- bhr_in  output  1  history shift-in bit; combinational copy of upd_taken

## Operation
- Counter encoding: 00 strong NT, 01 weak NT, 10 weak T, 11 strong T. Prediction = counter bit 1.
- Lookup index: pc_idx = pred_pc[IDX_W+1:2] (word aligned). Final index = pc_idx XOR {zeros, bhr} (bhr zero-extended into the low bits), subject to Configuration.
- Update, when upd_valid=1: taken increments the counter at upd_idx and saturates at 11. Not-taken decrements it and saturates at 00.
- Forwarding: a lookup and an update to the same index in the same cycle return the post-update counter's bit 1.
- A lookup and an update to different indices in the same cycle are independent. Both complete at that edge.
- bhr_en and bhr_in are combinational. The history register shifts at the same edge the counter is written.
- Lookups therefore see the pre-shift history in the update cycle. The shifted history is used from the next cycle.
- When pred_valid=0: pred_out_valid=0 at the next edge, and pred_taken and pred_idx hold their values.
- Reset (asynchronous, takes effect immediately, including mid-operation):
  - all counters = 01
  - pred_out_valid = 0, pred_taken = 0, pred_idx = 0
- While rst is asserted, bhr_en and bhr_in still follow upd_valid and upd_taken. The history register has its own reset.

## Timing
- Prediction latency is 1 cycle. A lookup with pred_valid high at edge N produces pred_out_valid, pred_taken and pred_idx valid from edge N until edge N+1.
- Back-to-back lookups are accepted every cycle with no stall.
- An update at edge N is visible to any lookup sampled at edge N or later (same-cycle forwarding).
- bhr_en and bhr_in have zero latency relative to upd_valid and upd_taken.
- There is no handshake. Both lookups and updates are always accepted.

## Configuration
- PHT_GSHARE_EN
  - Defined: index = pc_idx XOR zero-extended bhr (gshare).
  - Undefined: index = pc_idx (bimodal). The bhr input is ignored, and bhr_en and bhr_in are still driven.

## Test plan
- Reset: pulse rst, then look up pc=0x0000_0000, 0x0000_0004 and 0x0000_003C -> pred_taken=0 each; after updates, stepping confirms every counter restarted at 01.
- Training:
  - Updates to idx 3: taken, taken -> counter 11, lookup of idx 3 -> pred_taken=1.
  - Then not-taken, not-taken -> 01, pred_taken=0.
- Saturation:
  - 5 taken updates to idx 5, then 1 not-taken -> 10, pred_taken=1.
  - Then 5 not-taken -> 00, then 1 taken -> 01, pred_taken=0.
- Forwarding: idx 7 at 01; same-cycle lookup of idx 7 and upd_taken=1 -> pred_taken=1 next cycle; bhr_en=1 and bhr_in=1 in that cycle.
- Indexing (IDX_W=4, REGSIZE=2): pred_pc=0x0000_0010, bhr=2'b11 -> pred_idx=4'b0111 with PHT_GSHARE_EN, 4'b0100 without.
- Async reset mid-stream: during a run of lookups, assert rst between edges -> pred_out_valid, pred_taken and pred_idx go to 0 before the next edge; previously trained idx 3 predicts 0 after release.
